// File: rtl/nv_ram_rwsp_8x129_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nv_ram_rwsp_8x129_fifo_ctrl
// Brief    : Valid/ready streaming FIFO controller for one 8x129 two-port
//            register-file macro. It drives the macro write port, the
//            read-address latch (re) and the output-register enable (ore).
//            It also hides the 2-cycle read pipeline behind a stall-safe
//            output handshake. Capacity is 9 entries: 8 RAM slots plus the
//            macro output register.
// Options  : NV_FIFO_CTRL_RAM_PD_EN - when defined, forward pwrbus_ram_pd
//            to the macro. Otherwise the macro power-down bus is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module nv_ram_rwsp_8x129_fifo_ctrl (
    input  logic         clk,
    input  logic         rst,
    // producer side
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [128:0] wr_data,
    // consumer side
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [128:0] rd_data,
    // power control
    input  logic [31:0]  pwrbus_ram_pd,
    // macro write port
    output logic [2:0]   ram_wa,
    output logic         ram_we,
    output logic [128:0] ram_di,
    // macro read port
    output logic [2:0]   ram_ra,
    output logic         ram_re,
    output logic         ram_ore,
    input  logic [128:0] ram_dout,
    output logic [31:0]  ram_pwrbus_ram_pd,
    // status
    output logic [3:0]   occupancy
);

    localparam logic [3:0] c_ram_depth = 4'd8;

    logic [2:0] r_wptr;
    logic [2:0] r_rptr;
    logic [3:0] r_alloc_cnt;   // slots written but not yet captured by ore
    logic [3:0] r_avail_cnt;   // slots written but not yet issued by re
    logic       r_s1_vld;      // macro address latch holds an issued entry
    logic       r_s2_vld;      // macro output register holds an entry

    logic       w_push;
    logic       w_re;
    logic       w_ore;
    logic       w_s2_free;

    // Handshake and macro control decode; all enables are gated by rst
    always_comb begin
        w_s2_free = !r_s2_vld | rd_ready;
        wr_ready  = !rst & (r_alloc_cnt < c_ram_depth);
        w_push    = wr_valid & wr_ready;
        w_ore     = !rst & r_s1_vld & w_s2_free;
        w_re      = !rst & (r_avail_cnt != 4'd0) & (!r_s1_vld | w_ore);
    end

    assign ram_we    = w_push;
    assign ram_wa    = r_wptr;
    assign ram_di    = wr_data;
    assign ram_re    = w_re;
    assign ram_ra    = r_rptr;
    assign ram_ore   = w_ore;
    assign rd_valid  = r_s2_vld;
    assign rd_data   = ram_dout;
    assign occupancy = r_alloc_cnt + {3'b000, r_s2_vld};

`ifdef NV_FIFO_CTRL_RAM_PD_EN
    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;
`else
    // The power-down bus is intentionally ignored in this build
    logic w_pd_unused;
    assign w_pd_unused       = ^pwrbus_ram_pd;
    assign ram_pwrbus_ram_pd = 32'h0;
`endif

    // Write and read pointers advance on each push and issue respectively
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= 3'd0;
            r_rptr <= 3'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 3'd1;
            end
            if (w_re) begin
                r_rptr <= r_rptr + 3'd1;
            end
        end
    end

    // A slot is freed only when ore captures it. The RAM cell stays busy until then
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alloc_cnt <= 4'd0;
        end else begin
            case ({w_push, w_ore})
                2'b10:   r_alloc_cnt <= r_alloc_cnt + 4'd1;
                2'b01:   r_alloc_cnt <= r_alloc_cnt - 4'd1;
                default: r_alloc_cnt <= r_alloc_cnt;
            endcase
        end
    end

    // Count of written slots still waiting to be issued into the address latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_avail_cnt <= 4'd0;
        end else begin
            case ({w_push, w_re})
                2'b10:   r_avail_cnt <= r_avail_cnt + 4'd1;
                2'b01:   r_avail_cnt <= r_avail_cnt - 4'd1;
                default: r_avail_cnt <= r_avail_cnt;
            endcase
        end
    end

    // Two-stage read pipeline valid tracking (address latch, output register)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
        end else begin
            if (w_re) begin
                r_s1_vld <= 1'b1;
            end else if (w_ore) begin
                r_s1_vld <= 1'b0;
            end

            if (w_ore) begin
                r_s2_vld <= 1'b1;
            end else if (rd_ready) begin
                r_s2_vld <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nv_ram_rwsp_8x129_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nv_ram_rwsp_8x129_fifo_ctrl
// Brief    : Self-checking bench for nv_ram_rwsp_8x129_fifo_ctrl. It has a
//            behavioural model of the 8x129 macro and a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nv_ram_rwsp_8x129_fifo_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [128:0] wr_data = '0;
    logic         rd_valid;
    logic         rd_ready = 1'b0;
    logic [128:0] rd_data;
    logic [31:0]  pwrbus_ram_pd = 32'h0000_00A5;
    logic [2:0]   ram_wa;
    logic         ram_we;
    logic [128:0] ram_di;
    logic [2:0]   ram_ra;
    logic         ram_re;
    logic         ram_ore;
    logic [128:0] ram_dout;
    logic [31:0]  ram_pwrbus_ram_pd;
    logic [3:0]   occupancy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nv_ram_rwsp_8x129_fifo_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_data           (wr_data),
        .rd_valid          (rd_valid),
        .rd_ready          (rd_ready),
        .rd_data           (rd_data),
        .pwrbus_ram_pd     (pwrbus_ram_pd),
        .ram_wa            (ram_wa),
        .ram_we            (ram_we),
        .ram_di            (ram_di),
        .ram_ra            (ram_ra),
        .ram_re            (ram_re),
        .ram_ore           (ram_ore),
        .ram_dout          (ram_dout),
        .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd),
        .occupancy         (occupancy)
    );

    // Behavioural macro: write port, address latch on re, output register on ore
    logic [128:0] mem [0:7];
    logic [2:0]   ra_lat;
    logic [128:0] dout_reg;
    assign ram_dout = dout_reg;
    always @(posedge clk) begin
        if (ram_we)  mem[ram_wa] <= ram_di;
        if (ram_re)  ra_lat <= ram_ra;
        if (ram_ore) dout_reg <= mem[ra_lat];
    end

    // Scoreboard and reference counters, updated from the handshakes
    logic [128:0] sb_q [$];
    int           m_cnt = 0;
    logic [2:0]   m_wptr = 3'd0;
    logic [2:0]   m_rptr = 3'd0;
    logic         stall_prev = 1'b0;
    logic [128:0] prev_data;

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            m_cnt      = 0;
            m_wptr     = 3'd0;
            m_rptr     = 3'd0;
            stall_prev = 1'b0;
        end else begin
            n_checks++;
            if (occupancy !== 4'(m_cnt)) begin
                n_errors++;
                $display("FAIL occupancy: got %0d expected %0d at %0t", occupancy, m_cnt, $time);
            end
            if (ram_we) begin
                n_checks++;
                if (ram_wa !== m_wptr) begin
                    n_errors++;
                    $display("FAIL ram_wa: got %0d expected %0d at %0t", ram_wa, m_wptr, $time);
                end
                m_wptr = m_wptr + 3'd1;
            end
            if (ram_re) begin
                n_checks++;
                if (ram_ra !== m_rptr) begin
                    n_errors++;
                    $display("FAIL ram_ra: got %0d expected %0d at %0t", ram_ra, m_rptr, $time);
                end
                m_rptr = m_rptr + 3'd1;
            end
            if (stall_prev) begin
                n_checks++;
                if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
                    n_errors++;
                    $display("FAIL stall_stable: got v=%b d=%h expected v=1 d=%h at %0t",
                             rd_valid, rd_data, prev_data, $time);
                end
            end
            if (wr_valid && wr_ready) begin
                sb_q.push_back(wr_data);
                m_cnt++;
            end
            if (rd_valid && rd_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL pop_empty: got d=%h expected no output at %0t", rd_data, $time);
                end else begin
                    logic [128:0] exp_d;
                    exp_d = sb_q.pop_front();
                    if (rd_data !== exp_d) begin
                        n_errors++;
                        $display("FAIL pop_data: got %h expected %h at %0t", rd_data, exp_d, $time);
                    end
                end
                m_cnt--;
            end
            stall_prev = rd_valid && !rd_ready;
            prev_data  = rd_data;
        end
    end

    // Advance one cycle; inputs are applied and checked one delta after the posedge
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (wr_ready !== 1'b0 || ram_we !== 1'b0 || ram_re !== 1'b0 || ram_ore !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_enables: got rdy=%b we=%b re=%b ore=%b expected 0000",
                     wr_ready, ram_we, ram_re, ram_ore);
        end
        n_checks++;
        if (rd_valid !== 1'b0 || occupancy !== 4'd0 || ram_wa !== 3'd0 || ram_ra !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_state: got v=%b occ=%0d wa=%0d ra=%0d expected 0",
                     rd_valid, occupancy, ram_wa, ram_ra);
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        rst      = 1'b0;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_ready: got %b expected 1", wr_ready);
        end
`ifdef NV_FIFO_CTRL_RAM_PD_EN
        n_checks++;
        if (ram_pwrbus_ram_pd !== pwrbus_ram_pd) begin
            n_errors++;
            $display("FAIL pwrbus: got %h expected %h", ram_pwrbus_ram_pd, pwrbus_ram_pd);
        end
`else
        n_checks++;
        if (ram_pwrbus_ram_pd !== 32'h0) begin
            n_errors++;
            $display("FAIL pwrbus: got %h expected 0", ram_pwrbus_ram_pd);
        end
`endif
    endtask

    task automatic test_single_entry();
        do_reset();
        wr_valid = 1'b1;
        wr_data  = 129'h1_DEAD_BEEF;
        rd_ready = 1'b1;
        tick();
        wr_valid = 1'b0;
        #1;
        n_checks++;
        if (ram_re !== 1'b1 || ram_ore !== 1'b0 || rd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_c1: got re=%b ore=%b v=%b expected 1 0 0", ram_re, ram_ore, rd_valid);
        end
        tick();
        n_checks++;
        if (ram_re !== 1'b0 || ram_ore !== 1'b1 || rd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_c2: got re=%b ore=%b v=%b expected 0 1 0", ram_re, ram_ore, rd_valid);
        end
        tick();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 129'h1_DEAD_BEEF) begin
            n_errors++;
            $display("FAIL single_c3: got v=%b d=%h expected v=1 d=1deadbeef", rd_valid, rd_data);
        end
        tick();
        n_checks++;
        if (rd_valid !== 1'b0 || occupancy !== 4'd0) begin
            n_errors++;
            $display("FAIL single_c4: got v=%b occ=%0d expected 0 0", rd_valid, occupancy);
        end
    endtask

    task automatic test_fill_stall();
        int accepted;
        accepted = 0;
        do_reset();
        rd_ready = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            wr_valid = 1'b1;
            wr_data  = 129'(i);
            #1;
            if (wr_ready === 1'b1) accepted++;
            tick();
        end
        wr_valid = 1'b0;
        tick();
        n_checks++;
        if (accepted != 9) begin
            n_errors++;
            $display("FAIL fill_accepted: got %0d expected 9", accepted);
        end
        n_checks++;
        if (wr_ready !== 1'b0 || occupancy !== 4'd9) begin
            n_errors++;
            $display("FAIL fill_full: got rdy=%b occ=%0d expected 0 9", wr_ready, occupancy);
        end
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 129'd0) begin
            n_errors++;
            $display("FAIL fill_head: got v=%b d=%h expected 1 0", rd_valid, rd_data);
        end
    endtask

    task automatic test_drain_after_full();
        rd_ready = 1'b1;
        wr_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            #1;
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== 129'(k)) begin
                n_errors++;
                $display("FAIL drain_data[%0d]: got v=%b d=%h expected v=1 d=%0d", k, rd_valid, rd_data, k);
            end
            if (k <= 1) begin
                n_checks++;
                if (wr_ready !== (k == 1)) begin
                    n_errors++;
                    $display("FAIL drain_wr_ready[%0d]: got %b expected %b", k, wr_ready, (k == 1));
                end
            end
            tick();
        end
        n_checks++;
        if (rd_valid !== 1'b0 || occupancy !== 4'd0) begin
            n_errors++;
            $display("FAIL drain_empty: got v=%b occ=%0d expected 0 0", rd_valid, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rd_ready = 1'b1;
        for (int i = 0; i < 43; i++) begin
            wr_valid = (i < 40);
            wr_data  = 129'(1000 + i);
            #1;
            if (i < 40) begin
                n_checks++;
                if (wr_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL stream_ready[%0d]: got %b expected 1", i, wr_ready);
                end
            end
            n_checks++;
            if (i < 3) begin
                if (rd_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL stream_latency[%0d]: got %b expected 0", i, rd_valid);
                end
            end else if (rd_valid !== 1'b1 || rd_data !== 129'(1000 + i - 3)) begin
                n_errors++;
                $display("FAIL stream_out[%0d]: got v=%b d=%0d expected v=1 d=%0d",
                         i, rd_valid, rd_data, 1000 + i - 3);
            end
            tick();
        end
        wr_valid = 1'b0;
        #1;
        n_checks++;
        if (ram_wa !== 3'd0 || ram_ra !== 3'd0 || occupancy !== 4'd0 || rd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL stream_wrap: got wa=%0d ra=%0d occ=%0d v=%b expected 0 0 0 0",
                     ram_wa, ram_ra, occupancy, rd_valid);
        end
    endtask

    task automatic test_random_backpressure();
        logic [128:0] d;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            d[31:0]   = $urandom;
            d[63:32]  = $urandom;
            d[95:64]  = $urandom;
            d[127:96] = $urandom;
            d[128]    = 1'($urandom_range(0, 1));
            wr_valid  = ($urandom_range(0, 99) < 60);
            rd_ready  = ($urandom_range(0, 99) < 55);
            wr_data   = d;
            tick();
        end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (sb_q.size() != 0 || occupancy !== 4'd0) begin
            n_errors++;
            $display("FAIL random_drain: got left=%0d occ=%0d expected 0 0", sb_q.size(), occupancy);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 129'(8'hA0 + i);
            tick();
        end
        wr_valid = 1'b0;
        tick();
        n_checks++;
        if (rd_valid !== 1'b1 || occupancy !== 4'd5) begin
            n_errors++;
            $display("FAIL midrst_pre: got v=%b occ=%0d expected 1 5", rd_valid, occupancy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (wr_ready !== 1'b0 || ram_re !== 1'b0 || ram_ore !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_gate: got rdy=%b re=%b ore=%b expected 0 0 0", wr_ready, ram_re, ram_ore);
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (rd_valid !== 1'b0 || occupancy !== 4'd0) begin
            n_errors++;
            $display("FAIL midrst_post: got v=%b occ=%0d expected 0 0", rd_valid, occupancy);
        end
        wr_valid = 1'b1;
        wr_data  = 129'h5A5A;
        rd_ready = 1'b1;
        tick();
        wr_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            #1;
            n_checks++;
            if (c == 3) begin
                if (rd_valid !== 1'b1 || rd_data !== 129'h5A5A) begin
                    n_errors++;
                    $display("FAIL midrst_new: got v=%b d=%h expected v=1 d=5a5a", rd_valid, rd_data);
                end
            end else if (rd_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL midrst_stale[%0d]: got v=%b d=%h expected v=0", c, rd_valid, rd_data);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_entry();
        test_fill_stall();
        test_drain_after_full();
        test_back_to_back();
        test_random_backpressure();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
